adder_arbiter: RTL and testbench

- Shares one WIDTH-bit combinational adder between NREQ requesters.
- Each requester issues add or subtract operations over a valid/ready request channel.
- Requests are granted round-robin, executed on a single add_core instance, and returned on one shared response channel tagged with the requester id.
- Sits between ALU-side requesters (e.g. PC increment, address calc, ALU op) and the adder datapath.

---
 rtl/adder_arb_pkg.sv | 10 +
 rtl/add_core.sv | 16 +
 rtl/adder_arbiter.sv | 94 +++++++++
 tb/tb_adder_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM encoding and default sizing for the adder arbiter.
package adder_arb_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 2;
    localparam int DEF_IDW   = 2;
    localparam int DEF_CNTW  = 16;
endpackage

// File: rtl/add_core.sv
// add_core: combinational add/subtract with carry-out and signed overflow.
module add_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH-1:0] b_eff;
    assign b_eff = sub ? ~b : b;
    assign {cout, z} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) & (z[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder among NREQ requesters, one op in flight.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = DEF_IDW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_z,
    output logic                  rsp_cout,
    output logic                  rsp_ovf,
    output logic                  busy,
    output logic [CNTW-1:0]       op_count
);
    logic [1:0]       state;
    logic [IDW-1:0]   ptr, grant, cap_id;
    logic [WIDTH-1:0] cap_a, cap_b, sum;
    logic             cap_sub, cout, ovf, hs;

    // Scan descending so the lowest offset from the pointer is written last and wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        logic [IDW-1:0] g;
        g = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (v[(int'(p) + k) % NREQ]) g = IDW'((int'(p) + k) % NREQ);
        return g;
    endfunction

    assign grant     = rr_pick(req_valid, ptr);
    assign req_ready = (state == IDLE && |req_valid) ? NREQ'(1) << grant : '0;
    assign hs        = |(req_valid & req_ready);
    assign busy      = state != IDLE;

    add_core #(.WIDTH(WIDTH)) u_add (
        .a   (cap_a),
        .b   (cap_b),
        .sub (cap_sub),
        .z   (sum),
        .cout(cout),
        .ovf (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cap_id    <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_sub   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
            op_count  <= '0;
        end else if (state == IDLE) begin
            if (hs) begin
                cap_a   <= req_a[int'(grant)*WIDTH +: WIDTH];
                cap_b   <= req_b[int'(grant)*WIDTH +: WIDTH];
                cap_sub <= req_sub[grant];
                cap_id  <= grant;
                state   <= EXEC;
            end
        end else if (state == EXEC) begin
            rsp_z     <= sum;
            rsp_cout  <= cout;
            rsp_ovf   <= ovf;
            rsp_id    <= cap_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
        end else if (state == RESP) begin
            if (rsp_ready) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + CNTW'(1);
                ptr       <= (cap_id == IDW'(NREQ - 1)) ? '0 : cap_id + IDW'(1);
                state     <= IDLE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter (NREQ=2, CNTW=4 for counter wrap).
module tb_adder_arbiter;
    logic        clk = 0, rst_n = 0, rsp_ready = 0;
    logic [1:0]  req_valid = 0, req_ready, req_sub = 0;
    logic [63:0] req_a = 0, req_b = 0;
    logic        rsp_valid, rsp_cout, rsp_ovf, busy;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_z;
    logic [3:0]  op_count;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] z;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t       sb[$];
    int         total = 0, bad = 0, exp_ptr = 0;
    logic [3:0] exp_cnt = 0;

    adder_arbiter #(.WIDTH(32), .NREQ(2), .IDW(2), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_cout(rsp_cout),
        .rsp_ovf(rsp_ovf), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: subtract judged by unsigned compare and sign rules, not by ~B+1.
    function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t e;
        e.id = 2'(id);
        if (sub) begin
            e.z    = a - b;
            e.cout = a >= b;
            e.ovf  = (a[31] != b[31]) && (e.z[31] != a[31]);
        end else begin
            {e.cout, e.z} = {1'b0, a} + {1'b0, b};
            e.ovf = (a[31] == b[31]) && (e.z[31] != a[31]);
        end
        return e;
    endfunction

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_sub[id] = sub;
    endtask

    // Raise one request at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub, output bit ok);
        ok = 0;
        set_ops(id, a, b, sub);
        req_valid[id] = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1;
                sb.push_back(model(id, a, b, sub));
            end
            @(negedge clk);
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = -1;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid === 1'b1) begin
                n = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept(input int id);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        exp_ptr = (id + 1) % 2;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_z, rsp_cout, rsp_ovf, busy, op_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b v=%b id=%0d z=%h c=%b o=%b busy=%b cnt=%0d, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_z, rsp_cout, rsp_ovf, busy, op_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic [31:0] va[6], vb[6];
        logic        vs[6];
        int          vid[6], n;
        bit          ok;
        exp_t        e;
        va = '{32'h5, 32'h3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, $urandom, $urandom};
        vb = '{32'h3, 32'h5, 32'h1, 32'h1, $urandom, $urandom};
        vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vid = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            issue(vid[i], va[i], vb[i], vs[i], ok);
            total++;
            if (!ok) begin bad++; $display("FAIL arith_grant[%0d]: got no grant, want grant", i); end
            total++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL arith_exec[%0d]: got valid=%b busy=%b, want 0 1", i, rsp_valid, busy);
            end
            wait_rsp(n);
            total++;
            if (n !== 1) begin bad++; $display("FAIL arith_latency[%0d]: got %0d, want 1", i, n); end
            e = sb.size() ? sb.pop_front() : '0;
            total++;
            if ({rsp_id, rsp_z, rsp_cout, rsp_ovf} !== {e.id, e.z, e.cout, e.ovf}) begin
                bad++;
                $display("FAIL arith_result[%0d]: got id=%0d z=%h c=%b o=%b, want id=%0d z=%h c=%b o=%b",
                         i, rsp_id, rsp_z, rsp_cout, rsp_ovf, e.id, e.z, e.cout, e.ovf);
            end
            accept(vid[i]);
            total++;
            if (op_count !== exp_cnt || rsp_valid !== 1'b0) begin
                bad++; $display("FAIL arith_count[%0d]: got cnt=%0d v=%b, want cnt=%0d v=0", i, op_count, rsp_valid, exp_cnt);
            end
        end
    endtask

    task automatic test_fairness();
        logic [31:0] fa[2], fb[2];
        logic        fs[2];
        int          done = 0;
        exp_t        e;
        fa = '{32'd100, 32'd50};
        fb = '{32'd1, 32'd20};
        fs = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) set_ops(i, fa[i], fb[i], fs[i]);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && done < 6; c++) begin
            #1;
            if (|req_ready) begin
                total++;
                if (req_ready !== 2'(1 << exp_ptr)) begin
                    bad++; $display("FAIL fair_grant: got %b, want %b", req_ready, 2'(1 << exp_ptr));
                end
                sb.push_back(model(exp_ptr, fa[exp_ptr], fb[exp_ptr], fs[exp_ptr]));
            end
            if (rsp_valid) begin
                e = sb.size() ? sb.pop_front() : '0;
                total++;
                if ({rsp_id, rsp_z} !== {e.id, e.z}) begin
                    bad++; $display("FAIL fair_rsp[%0d]: got id=%0d z=%h, want id=%0d z=%h", done, rsp_id, rsp_z, e.id, e.z);
                end
                exp_ptr = (int'(e.id) + 1) % 2;
                exp_cnt = exp_cnt + 4'd1;
                done++;
                if (done == 6) req_valid = 2'b00;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        total++;
        if (done != 6) begin bad++; $display("FAIL fair_done: got %0d ops, want 6", done); end
        @(negedge clk);
        total++;
        if (op_count !== exp_cnt || busy !== 1'b0) begin
            bad++; $display("FAIL fair_count: got cnt=%0d busy=%b, want cnt=%0d busy=0", op_count, busy, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        int   n;
        bit   ok;
        exp_t e;
        issue(1, 32'h1234_0000, 32'h0000_5678, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_grant: got no grant, want grant"); end
        set_ops(0, 32'd9, 32'd4, 1'b1);
        req_valid[0] = 1'b1;
        wait_rsp(n);
        total++;
        if (n < 0) begin bad++; $display("FAIL bp_timeout: got no response, want response"); end
        e = sb.size() ? sb.pop_front() : '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_z} !== {e.id, e.z} || req_ready !== 2'b00 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d z=%h rdy=%b busy=%b, want v=1 id=%0d z=%h rdy=00 busy=1",
                         c, rsp_valid, rsp_id, rsp_z, req_ready, busy, e.id, e.z);
            end
            @(negedge clk);
        end
        accept(1);
        #1;
        total++;
        if (req_ready !== 2'(1 << exp_ptr) || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_next_grant: got rdy=%b v=%b, want rdy=%b v=0", req_ready, rsp_valid, 2'(1 << exp_ptr));
        end
        sb.push_back(model(0, 32'd9, 32'd4, 1'b1));
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(n);
        e = sb.size() ? sb.pop_front() : '0;
        total++;
        if (n < 0 || {rsp_id, rsp_z, rsp_cout, rsp_ovf} !== {e.id, e.z, e.cout, e.ovf}) begin
            bad++; $display("FAIL bp_second: got n=%0d id=%0d z=%h c=%b, want id=%0d z=%h c=%b", n, rsp_id, rsp_z, rsp_cout, e.id, e.z, e.cout);
        end
        accept(0);
    endtask

    task automatic test_reset_midop();
        bit ok;
        issue(0, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, ok);
        total++;
        if (!ok || busy !== 1'b1) begin bad++; $display("FAIL rst_setup: got ok=%b busy=%b, want 1 1", ok, busy); end
        rst_n = 0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_z, rsp_cout, rsp_ovf, busy, op_count} !== '0) begin
            bad++;
            $display("FAIL rst_midop: got rdy=%b v=%b id=%0d z=%h busy=%b cnt=%0d, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_z, busy, op_count);
        end
        sb.delete();
        exp_cnt = 0;
        exp_ptr = 0;
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL rst_stale[%0d]: got v=%b busy=%b, want 0 0", c, rsp_valid, busy);
            end
        end
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_ptr: got %b, want 01", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int          n;
        bit          ok;
        exp_t        e;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            issue(i % 2, a, b, 1'(i / 3), ok);
            wait_rsp(n);
            e = sb.size() ? sb.pop_front() : '0;
            total++;
            if (!ok || n < 0 || {rsp_id, rsp_z, rsp_cout, rsp_ovf} !== {e.id, e.z, e.cout, e.ovf}) begin
                bad++;
                $display("FAIL wrap_rsp[%0d]: got ok=%b n=%0d id=%0d z=%h c=%b o=%b, want id=%0d z=%h c=%b o=%b",
                         i, ok, n, rsp_id, rsp_z, rsp_cout, rsp_ovf, e.id, e.z, e.cout, e.ovf);
            end
            accept(i % 2);
            total++;
            if (op_count !== exp_cnt) begin bad++; $display("FAIL wrap_count[%0d]: got %0d, want %0d", i, op_count, exp_cnt); end
        end
        total++;
        if (op_count !== 4'd0) begin bad++; $display("FAIL wrap_zero: got %0d, want 0", op_count); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_fairness();
        test_backpressure();
        test_reset_midop();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
